// File: rtl/backend_pkg.sv
// Shared arbitration types and helpers for the backend stream/command arbiters.
package backend_pkg;

  localparam int NMODULES = 4;
  localparam int LENGTH   = 128;
  localparam int PTR_W    = $clog2(NMODULES);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First requesting index after ptr (wrapping); returns ptr when nothing requests.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr,
                                               input logic [NMODULES-1:0] req);
    logic [PTR_W-1:0] sel;
    int               cand;
    sel = ptr;
    for (int k = NMODULES; k >= 1; k--) begin
      cand = (int'(ptr) + k) % NMODULES;
      if (req[cand[PTR_W-1:0]]) begin
        sel = cand[PTR_W-1:0];
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/module_data_arbiter_rr_select.sv
// Combinational round-robin picker: first set bit of i_req after i_ptr, wrapping mod N.
module rr_select #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [PW-1:0] o_idx,
  output logic          o_found
);

  int w_cand;

  // Scan from the farthest candidate down so the nearest one after i_ptr wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_cand  = 0;
    for (int k = N; k >= 1; k--) begin
      w_cand = (int'(i_ptr) + k) % N;
      if (i_req[w_cand[PW-1:0]]) begin
        o_idx   = w_cand[PW-1:0];
        o_found = 1'b1;
      end else begin
        o_found = o_found;
      end
    end
  end

endmodule

// File: rtl/module_data_arbiter.sv
// Round-robin, burst-limited merge of per-module word streams into one registered output.
// Define MODULE_ARB_COUNTERS_EN for per-module word counters and an output stall counter.
module module_data_arbiter #(
  parameter int NMODULES  = backend_pkg::NMODULES,
  parameter int LENGTH    = backend_pkg::LENGTH,
  parameter int MAX_BURST = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NMODULES-1:0]         enable_mask,
  input  logic [NMODULES-1:0]         in_valid,
  output logic [NMODULES-1:0]         in_ready,
  input  logic [NMODULES*LENGTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LENGTH-1:0]           out_data,
  output logic [$clog2(NMODULES)-1:0] out_src,
  output logic                        busy
`ifdef MODULE_ARB_COUNTERS_EN
  ,
  input  logic [$clog2(NMODULES)-1:0] cnt_sel,
  input  logic                        cnt_clear,
  output logic [31:0]                 cnt_value,
  output logic [31:0]                 stall_cycles
`endif
);

  import backend_pkg::*;

  localparam int SRC_W = $clog2(NMODULES);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

  state_t              r_state;
  logic [SRC_W-1:0]    r_gnt_idx;
  logic [SRC_W-1:0]    r_rr_ptr;
  logic [CNT_W-1:0]    r_burst_cnt;
  logic                r_out_valid;
  logic [LENGTH-1:0]   r_out_data;
  logic [SRC_W-1:0]    r_out_src;

  logic                w_load_ok;
  logic                w_xfer;
  logic                w_sel_found;
  logic                w_gnt_en;
  logic                w_gnt_valid;
  logic [NMODULES-1:0] w_req;
  logic [NMODULES-1:0] w_in_ready;
  logic [SRC_W-1:0]    w_sel_idx;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [LENGTH-1:0]   w_gnt_data;

  assign w_req       = in_valid & enable_mask;
  assign w_load_ok   = ~r_out_valid | out_ready;
  assign w_gnt_en    = enable_mask[r_gnt_idx];
  assign w_gnt_valid = in_valid[r_gnt_idx];
  assign w_cnt_inc   = r_burst_cnt + 1'b1;
  assign w_xfer      = |(w_in_ready & in_valid);

  rr_select #(
    .N  (NMODULES),
    .PW (SRC_W)
  ) u_rr_select (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_sel_idx),
    .o_found (w_sel_found)
  );

  // Ready decode for the granted module (gated by its enable) and granted-word mux.
  always_comb begin
    w_in_ready = '0;
    w_gnt_data = '0;
    for (int i = 0; i < NMODULES; i++) begin
      if (r_gnt_idx == SRC_W'(i)) begin
        w_in_ready[i] = (r_state == GRANT) & enable_mask[i] & w_load_ok;
        w_gnt_data    = in_data[i*LENGTH +: LENGTH];
      end else begin
        w_in_ready[i] = 1'b0;
      end
    end
  end

  // Arbitration FSM; the grant cycle itself moves no data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gnt_idx   <= '0;
      r_rr_ptr    <= SRC_W'(NMODULES - 1);
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sel_found) begin
            r_gnt_idx   <= w_sel_idx;
            r_burst_cnt <= '0;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          if (!w_gnt_en || (w_load_ok && !w_gnt_valid)) begin
            r_state  <= IDLE;
            r_rr_ptr <= r_gnt_idx;
          end else if (w_load_ok) begin
            r_burst_cnt <= w_cnt_inc;
            if (w_cnt_inc == BURST_LAST) begin
              r_state  <= IDLE;
              r_rr_ptr <= r_gnt_idx;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output register: holds steady while the downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_load_ok) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_gnt_data;
        r_out_src  <= r_gnt_idx;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign busy      = (r_state == GRANT);

`ifdef MODULE_ARB_COUNTERS_EN
  logic [31:0] r_cnt [NMODULES];
  logic [31:0] r_cnt_value;
  logic [31:0] r_stall;

  // Word counters (clear beats a simultaneous transfer), readback and saturating stall count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NMODULES; i++) begin
        r_cnt[i] <= 32'd0;
      end
      r_cnt_value <= 32'd0;
      r_stall     <= 32'd0;
    end else begin
      for (int i = 0; i < NMODULES; i++) begin
        if (cnt_clear && (cnt_sel == SRC_W'(i))) begin
          r_cnt[i] <= 32'd0;
        end else if (w_in_ready[i] && in_valid[i]) begin
          r_cnt[i] <= r_cnt[i] + 32'd1;
        end
      end
      r_cnt_value <= r_cnt[cnt_sel];
      if (cnt_clear) begin
        r_stall <= 32'd0;
      end else if (r_out_valid && !out_ready && (r_stall != 32'hFFFF_FFFF)) begin
        r_stall <= r_stall + 32'd1;
      end
    end
  end

  assign cnt_value    = r_cnt_value;
  assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_module_data_arbiter.sv
// Self-checking bench for module_data_arbiter: vector table, directed corner sequences,
// and random traffic against a cycle-level reference model of the arbitration rules.
module tb_module_data_arbiter;

  localparam int N  = 4;
  localparam int L  = 128;
  localparam int MB = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   enable_mask = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [N*L-1:0] in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [L-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           busy;
`ifdef MODULE_ARB_COUNTERS_EN
  logic [SW-1:0]  cnt_sel = 2'd3;
  logic           cnt_clear = 1'b0;
  logic [31:0]    cnt_value;
  logic [31:0]    stall_cycles;
`endif

  always #5 clk = ~clk;

  module_data_arbiter #(.NMODULES(N), .LENGTH(L), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_mask  (enable_mask),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_src      (out_src),
    .busy         (busy)
`ifdef MODULE_ARB_COUNTERS_EN
    ,
    .cnt_sel      (cnt_sel),
    .cnt_clear    (cnt_clear),
    .cnt_value    (cnt_value),
    .stall_cycles (stall_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  // stimulus state and reference model
  logic [N-1:0] s_valid = '0;
  logic [N-1:0] s_en = '1;
  logic         s_ordy = 1'b1;
  int           seq [N];
  int           got_seq [N];
  int           got_cnt [N];
  int           m_owner, m_used, m_last, m_os;
  bit           m_ov;
  logic [L-1:0] m_od;
  logic [N-1:0] last_rdy;
  bit           last_new;

  typedef struct {
    logic [3:0] en;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic [1:0] e_src;
    logic       e_busy;
  } vec_t;
  vec_t tv [9];

  function automatic logic [L-1:0] mkword(input int m, input int s);
    return {16'hC0DE, 16'(m), 64'h0, 32'(s)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, check ready mid-cycle, check registers after the edge.
  task automatic step();
    logic [N-1:0] exp_rdy;
    logic [L-1:0] xd;
    bit           lok, x;
    int           g;
    enable_mask = s_en;
    in_valid    = s_valid;
    out_ready   = s_ordy;
    for (int i = 0; i < N; i++) in_data[i*L +: L] = mkword(i, seq[i]);
    #1;
    lok = !m_ov || s_ordy;
    exp_rdy = '0; x = 1'b0; g = 0; xd = '0;
    if (m_owner >= 0 && s_en[m_owner] && lok) exp_rdy[m_owner] = 1'b1;
    last_rdy = in_ready;
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    if (m_owner >= 0) begin
      g  = m_owner;
      x  = exp_rdy[g] && s_valid[g];
      xd = mkword(g, seq[g]);
      if (!s_en[g] || (lok && !s_valid[g])) begin
        m_last = g; m_owner = -1;
      end else if (x) begin
        m_used++;
        if (m_used == MB) begin m_last = g; m_owner = -1; end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (m_owner < 0 && s_valid[j] && s_en[j]) begin m_owner = j; m_used = 0; end
      end
    end
    if (lok) m_ov = x;
    if (x) begin m_od = xd; m_os = g; seq[g]++; end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", 128'(out_valid), 128'(m_ov));
    chk("out_data", out_data, m_od);
    chk("out_src", 128'(out_src), 128'(m_os));
    chk("busy", 128'(busy), 128'(m_owner >= 0));
    last_new = x;
    if (x && out_valid === 1'b1) begin
      chk("seq_order", 128'(out_data[31:0]), 128'(got_seq[out_src]));
      got_seq[out_src]++;
      got_cnt[out_src]++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = '1; s_en = '1; s_ordy = 1'b1;
    enable_mask = s_en; in_valid = s_valid; out_ready = s_ordy;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_out_src", 128'(out_src), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    m_owner = -1; m_used = 0; m_last = N - 1; m_ov = 1'b0; m_od = '0; m_os = 0;
    for (int i = 0; i < N; i++) got_seq[i] = seq[i];
    rst = 1'b0;
  endtask

  initial begin
    int   base, c1, c2, wd, prev, tot, lo, hi;
    int   st [N];
    bit   found, done;
    logic [21:0]  pat;
    int   np;
    logic [L-1:0] held;

    for (int i = 0; i < N; i++) begin seq[i] = 0; got_seq[i] = 0; got_cnt[i] = 0; end
    tv[0] = '{4'hF,    4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};
    tv[1] = '{4'hF,    4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    tv[2] = '{4'hF,    4'b0000, 1'b1, 4'b0010, 1'b0, 2'd1, 1'b0};
    tv[3] = '{4'hF,    4'b0101, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1};
    tv[4] = '{4'hF,    4'b0101, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1};
    tv[5] = '{4'hF,    4'b0101, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1};
    tv[6] = '{4'b1011, 4'b0101, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0};
    tv[7] = '{4'b1011, 4'b0101, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1};
    tv[8] = '{4'hF,    4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};

    // vector table from reset
    do_reset();
    for (int t = 0; t < 9; t++) begin
      s_en = tv[t].en; s_valid = tv[t].valid; s_ordy = tv[t].ordy;
      step();
      chk("tv_rdy", 128'(last_rdy), 128'(tv[t].e_rdy));
      chk("tv_ov", 128'(out_valid), 128'(tv[t].e_ov));
      chk("tv_src", 128'(out_src), 128'(tv[t].e_src));
      chk("tv_busy", 128'(busy), 128'(tv[t].e_busy));
    end

    // single requester: 20 words -> 8, bubble, 8, bubble, 4
    do_reset();
    s_en = '1; s_ordy = 1'b1; base = seq[1]; c1 = got_cnt[1]; pat = '0; np = 0;
    for (int c = 0; c < 40; c++) begin
      s_valid = (seq[1] - base < 20) ? 4'b0010 : 4'b0000;
      step();
      if (np < 22 && (np > 0 || out_valid === 1'b1)) begin pat = {pat[20:0], out_valid}; np++; end
    end
    chk("single_pattern", 128'(pat), 128'(22'b1111111101111111101111));
    chk("single_words", 128'(got_cnt[1] - c1), 128'(20));

    // all modules busy: rotation 0,1,2,3 and fair share
    do_reset();
    s_en = '1; s_valid = '1; s_ordy = 1'b1; prev = -1;
    for (int i = 0; i < N; i++) st[i] = got_cnt[i];
    for (int c = 0; c < 400; c++) begin
      step();
      if (last_new && out_valid === 1'b1) begin
        if (prev >= 0 && int'(out_src) != prev) chk("rotation", 128'(out_src), 128'((prev + 1) % N));
        prev = int'(out_src);
      end
    end
    tot = 0;
    for (int i = 0; i < N; i++) tot += got_cnt[i] - st[i];
    lo = tot / N - MB; hi = tot / N + MB;
    for (int i = 0; i < N; i++)
      chk("fair_share", 128'((got_cnt[i] - st[i] >= lo) && (got_cnt[i] - st[i] <= hi)), 128'(1));

    // back-pressure mid-burst on module 0
    do_reset();
    s_en = '1; s_valid = 4'b0001; s_ordy = 1'b1; wd = 0;
    for (int c = 0; c < 20; c++) if (wd < 3) begin step(); if (last_new) wd++; end
    chk("bp_start", 128'(wd), 128'(3));
    held = out_data;
    s_ordy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_data", out_data, held);
      chk("bp_no_ready", 128'(last_rdy), 128'(0));
    end
    s_ordy = 1'b1; done = 1'b0;
    for (int c = 0; c < 20; c++) if (!done) begin
      step();
      if (last_new) wd++;
      if (out_valid !== 1'b1) done = 1'b1;
    end
    chk("bp_burst_len", 128'(wd), 128'(MB));

    // enable drop during module 2 burst after 3 words
    do_reset();
    s_en = '1; s_valid = 4'b1100; s_ordy = 1'b1; base = seq[2]; c2 = got_cnt[2];
    for (int c = 0; c < 20; c++) if (seq[2] - base < 3) step();
    chk("en_pre_words", 128'(got_cnt[2] - c2), 128'(3));
    s_en = 4'b1011;
    step();
    chk("en_ready_drop", 128'(last_rdy[2]), 128'(0));
    found = 1'b0;
    for (int c = 0; c < 20; c++) if (!found) begin
      step();
      if (last_new) begin chk("en_next_src", 128'(out_src), 128'(3)); found = 1'b1; end
    end
    chk("en_next_seen", 128'(found), 128'(1));
    for (int c = 0; c < 10; c++) step();
    chk("en_words", 128'(got_cnt[2] - c2), 128'(3));

    // asynchronous reset with a word in the output register
    do_reset();
    s_en = '1; s_valid = '1; s_ordy = 1'b1;
    for (int c = 0; c < 10; c++) if (out_valid !== 1'b1) step();
    chk("arst_pre_valid", 128'(out_valid), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    do_reset();
    s_en = '1; s_valid = '1; s_ordy = 1'b1; found = 1'b0;
    for (int c = 0; c < 10; c++) if (!found) begin
      step();
      if (last_new) begin chk("arst_first_src", 128'(out_src), 128'(0)); found = 1'b1; end
    end
    chk("arst_first_seen", 128'(found), 128'(1));

    // random traffic against the model
    do_reset();
    s_en = '1;
    for (int c = 0; c < 1500; c++) begin
      s_valid = 4'($urandom);
      s_ordy  = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) s_en[$urandom_range(3, 0)] ^= 1'b1;
      if ($urandom_range(63, 0) == 0) s_en = '1;
      step();
    end

`ifdef MODULE_ARB_COUNTERS_EN
    // word counter readback and clear
    do_reset();
    s_en = '1; s_ordy = 1'b1; cnt_sel = 2'd3; cnt_clear = 1'b0; base = seq[3];
    for (int c = 0; c < 40; c++) begin
      s_valid = (seq[3] - base < 10) ? 4'b1000 : 4'b0000;
      step();
    end
    chk("cnt_value", 128'(cnt_value), 128'(10));
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("cnt_clear_lat", 128'(cnt_value), 128'(10));
    step();
    chk("cnt_cleared", 128'(cnt_value), 128'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
